// File: rtl/timer_irq_master.sv
// timer_irq_master: Avalon-MM master that programs the interval timer over its
// 16-bit s1 port, services its interrupt and keeps a 32-bit tick count.
// Optional feature macro: TIMER_MASTER_SNAPSHOT_EN. When defined, each serviced
// interrupt also captures the timer counter through snap_l/snap_h and
// presents it on snapshot.
module timer_irq_master #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       period,
    input  logic              continuous,
    input  logic              irq,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    output logic              busy,
    output logic              tick,
    output logic [31:0]       tick_count,
    output logic [31:0]       snapshot
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_W_STOP   = 4'd1;
    localparam logic [3:0] S_W_PL     = 4'd2;
    localparam logic [3:0] S_W_PH     = 4'd3;
    localparam logic [3:0] S_W_CTRL   = 4'd4;
    localparam logic [3:0] S_WAIT_IRQ = 4'd5;
    localparam logic [3:0] S_W_CLR    = 4'd6;
    localparam logic [3:0] S_DONE     = 4'd7;
    localparam logic [3:0] S_STOPPING = 4'd8;
`ifdef TIMER_MASTER_SNAPSHOT_EN
    localparam logic [3:0] S_SNAP     = 4'd9;
    localparam logic [3:0] S_RD_SL    = 4'd10;
    localparam logic [3:0] S_RD_SH    = 4'd11;
`endif

    // Timer register word addresses
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_PL     = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_PH     = ADDR_W'(3);
`ifdef TIMER_MASTER_SNAPSHOT_EN
    localparam logic [ADDR_W-1:0] A_SNAP_L = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_SNAP_H = ADDR_W'(5);
`endif

    localparam logic [15:0] CTRL_STOP = 16'h0008;

    logic [3:0]        state_q, state_d;
    logic [31:0]       period_q;
    logic              cont_q;
    logic              stop_pending_q, stop_pending_d;
    logic              avm_write_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, tick_q;
    logic [31:0]       tick_count_q;
    logic              start_ok, go_stop, wr_done, rd_done;

    assign start_ok = (state_q == S_IDLE) && start;
    assign go_stop  = stop_pending_q || stop;
    assign wr_done  = avm_write_q && !avm_waitrequest;

    // A stop is remembered until the current bus access lets us act on it
    assign stop_pending_d = ((state_q == S_IDLE) || (state_q == S_STOPPING)) ? 1'b0 : go_stop;

`ifdef TIMER_MASTER_SNAPSHOT_EN
    logic              avm_read_q, rd_d, in_rd_d;
    logic              rd_waiting_q, rd_waiting_d, rd_accept;
    logic [DATA_W-1:0] snap_lo_q;
    logic [31:0]       snapshot_q;

    assign rd_accept    = avm_read_q && !avm_waitrequest;
    assign rd_done      = rd_waiting_q && avm_readdatavalid;
    assign rd_waiting_d = rd_accept || (rd_waiting_q && !avm_readdatavalid);
    assign in_rd_d      = (state_d == S_RD_SL) || (state_d == S_RD_SH);
    // Raise read on entry to a read state, hold it only while stalled
    assign rd_d         = in_rd_d && ((state_d != state_q) || (avm_read_q && avm_waitrequest));
`else
    logic unused_rd;
    assign unused_rd = ^{avm_readdata, avm_readdatavalid};
    assign rd_done   = 1'b0;
`endif

    // Next-state: each bus state advances only once its access completes
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_W_STOP;
            S_W_STOP:   if (wr_done) state_d = go_stop ? S_STOPPING : S_W_PL;
            S_W_PL:     if (wr_done) state_d = go_stop ? S_STOPPING : S_W_PH;
            S_W_PH:     if (wr_done) state_d = go_stop ? S_STOPPING : S_W_CTRL;
            S_W_CTRL:   if (wr_done) state_d = go_stop ? S_STOPPING : S_WAIT_IRQ;
            S_WAIT_IRQ: begin
                if (go_stop) state_d = S_STOPPING;
                else if (irq) state_d = S_W_CLR;
            end
`ifdef TIMER_MASTER_SNAPSHOT_EN
            S_W_CLR:    if (wr_done) state_d = go_stop ? S_STOPPING : S_SNAP;
            S_SNAP:     if (wr_done) state_d = go_stop ? S_STOPPING : S_RD_SL;
            S_RD_SL:    if (rd_done) state_d = go_stop ? S_STOPPING : S_RD_SH;
            S_RD_SH:    if (rd_done) state_d = go_stop ? S_STOPPING : S_DONE;
`else
            S_W_CLR:    if (wr_done) state_d = go_stop ? S_STOPPING : S_DONE;
`endif
            S_DONE:     state_d = go_stop ? S_STOPPING : (cont_q ? S_WAIT_IRQ : S_IDLE);
            S_STOPPING: if (wr_done) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Bus request decoded from the state being entered so outputs can be registered
    always_comb begin
        wr_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_d)
            S_W_STOP: begin
                wr_d = 1'b1; addr_d = A_CTRL; wdata_d = DATA_W'(CTRL_STOP);
            end
            S_W_PL: begin
                wr_d = 1'b1; addr_d = A_PL; wdata_d = DATA_W'(period_q[15:0]);
            end
            S_W_PH: begin
                wr_d = 1'b1; addr_d = A_PH; wdata_d = DATA_W'(period_q[31:16]);
            end
            S_W_CTRL: begin
                wr_d = 1'b1; addr_d = A_CTRL;
                wdata_d = DATA_W'({12'b0, 1'b0, 1'b1, cont_q, 1'b1});
            end
            S_W_CLR: begin
                wr_d = 1'b1; addr_d = A_STATUS; wdata_d = '0;
            end
            S_STOPPING: begin
                wr_d = 1'b1; addr_d = A_CTRL; wdata_d = DATA_W'(CTRL_STOP);
            end
`ifdef TIMER_MASTER_SNAPSHOT_EN
            S_SNAP: begin
                wr_d = 1'b1; addr_d = A_SNAP_L; wdata_d = '0;
            end
            S_RD_SL: addr_d = A_SNAP_L;
            S_RD_SH: addr_d = A_SNAP_H;
`endif
            default: ;
        endcase
    end

    // State, bus outputs and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            period_q       <= '0;
            cont_q         <= 1'b0;
            stop_pending_q <= 1'b0;
            avm_write_q    <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            busy_q         <= 1'b0;
            tick_q         <= 1'b0;
            tick_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            stop_pending_q <= stop_pending_d;
            avm_write_q    <= wr_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            busy_q         <= (state_d != S_IDLE);
            tick_q         <= (state_d == S_DONE);
            if (start_ok) begin
                period_q     <= period;
                cont_q       <= continuous;
                tick_count_q <= '0;
            end else if (state_d == S_DONE) begin
                tick_count_q <= tick_count_q + 32'd1;
            end
        end
    end

`ifdef TIMER_MASTER_SNAPSHOT_EN
    // Read handshake and snapshot capture; snapshot lands with the tick pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_read_q   <= 1'b0;
            rd_waiting_q <= 1'b0;
            snap_lo_q    <= '0;
            snapshot_q   <= '0;
        end else begin
            avm_read_q   <= rd_d;
            rd_waiting_q <= rd_waiting_d;
            if (rd_done && (state_q == S_RD_SL)) snap_lo_q <= avm_readdata;
            if (rd_done && (state_q == S_RD_SH) && (state_d == S_DONE)) begin
                snapshot_q <= {avm_readdata, snap_lo_q};
            end
        end
    end

    assign avm_read = avm_read_q;
    assign snapshot = snapshot_q;
`else
    assign avm_read = 1'b0;
    assign snapshot = '0;
`endif

    assign avm_address   = addr_q;
    assign avm_write     = avm_write_q;
    assign avm_writedata = wdata_q;
    assign busy          = busy_q;
    assign tick          = tick_q;
    assign tick_count    = tick_count_q;

endmodule
